// File: rtl/hazard_forward_unit.sv
// ---------------------------------------------------------------------------
// hazard_forward_unit
//
// Hazard detection and operand-forwarding control for the 4-stage
// (D, EX, MEM, WB) 16-bit core. It looks at the decode-side control and
// register addresses that are about to enter the ID/EX register. From them
// it drives:
//   - the fetch/decode stall lines;
//   - the IF/ID flush;
//   - the ID/EX bubble;
//   - registered forwarding selects that line up with the EX stage.
// The unit keeps its own shadow copy of the write-back info of the
// instructions now in EX and MEM. It also keeps two saturating performance
// counters.
//
// Ports
//   clk, reset      core clock; synchronous active-high reset
//   validD          decode stage holds a real instruction
//   srcAddD1/2      decode source register addresses
//   useSrcD1/2      decode instruction actually reads that source
//   destAddD        decode destination register
//   RegWriteC       decode instruction writes a register
//   MemToRegC       decode instruction is a load
//   branchTakenE    EX resolved a taken branch this cycle
//   stallF, stallD  hold PC / IF/ID register   (combinational)
//   flushD          clear IF/ID register       (combinational)
//   flushC          bubble into ID/EX register (combinational)
//   fwdSelE1/2      EX operand source: 00 regfile, 01 MEM result, 10 WB result
//   stallCount      cycles spent in a load-use stall (saturating)
//   flushCount      cycles with a branch flush (saturating)
//
// Interface timing: this block has no valid/ready handshake. The control
// outputs act in the cycle they are raised. The forwarding selects are valid
// in the cycle after the decode inputs are presented, which is the cycle
// that instruction occupies EX.
// ---------------------------------------------------------------------------
module hazard_forward_unit #(
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              validD,
    input  logic [ADDR_W-1:0] srcAddD1,
    input  logic [ADDR_W-1:0] srcAddD2,
    input  logic              useSrcD1,
    input  logic              useSrcD2,
    input  logic [ADDR_W-1:0] destAddD,
    input  logic              RegWriteC,
    input  logic              MemToRegC,
    input  logic              branchTakenE,
    output logic              stallF,
    output logic              stallD,
    output logic              flushD,
    output logic              flushC,
    output logic [1:0]        fwdSelE1,
    output logic [1:0]        fwdSelE2,
    output logic [CNT_W-1:0]  stallCount,
    output logic [CNT_W-1:0]  flushCount
);

    // Forwarding select encodings
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // -----------------------------------------------------------------------
    // Shadow pipeline state
    // -----------------------------------------------------------------------
    logic              ex_v_q,   ex_v_d;
    logic              ex_rw_q,  ex_rw_d;
    logic              ex_ld_q,  ex_ld_d;
    logic [ADDR_W-1:0] ex_dst_q, ex_dst_d;

    logic              mem_v_q,   mem_v_d;
    logic              mem_rw_q,  mem_rw_d;
    logic [ADDR_W-1:0] mem_dst_q, mem_dst_d;

    logic [1:0]        fwd_sel1_q, fwd_sel1_d;
    logic [1:0]        fwd_sel2_q, fwd_sel2_d;

    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    // -----------------------------------------------------------------------
    // Dependency matches between decode sources and in-flight writers
    // -----------------------------------------------------------------------
    logic match_ex1, match_ex2;
    logic match_mem1, match_mem2;
    logic load_use;

    always_comb begin
        match_ex1  = validD & useSrcD1 & ex_v_q  & ex_rw_q  & (ex_dst_q  == srcAddD1);
        match_ex2  = validD & useSrcD2 & ex_v_q  & ex_rw_q  & (ex_dst_q  == srcAddD2);
        match_mem1 = validD & useSrcD1 & mem_v_q & mem_rw_q & (mem_dst_q == srcAddD1);
        match_mem2 = validD & useSrcD2 & mem_v_q & mem_rw_q & (mem_dst_q == srcAddD2);
        // A load result only exists at the end of MEM. A consumer directly
        // behind a load must therefore wait one cycle.
        load_use   = ex_ld_q & (match_ex1 | match_ex2);
    end

    // -----------------------------------------------------------------------
    // Stall / flush control (combinational, same-cycle effect)
    // -----------------------------------------------------------------------
    always_comb begin
        stallF = 1'b0;
        stallD = 1'b0;
        flushD = 1'b0;
        flushC = 1'b0;
        if (!reset) begin
            if (branchTakenE) begin
                // The wrong-path instruction in D is discarded. Stalling it
                // would be pointless, so the branch wins over load-use.
                flushD = 1'b1;
                flushC = 1'b1;
            end else if (load_use) begin
                stallF = 1'b1;
                stallD = 1'b1;
                flushC = 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Next-state: shadow advance, forwarding selects, counters
    // -----------------------------------------------------------------------
    always_comb begin
        // MEM inherits whatever was in EX
        mem_v_d   = ex_v_q;
        mem_rw_d  = ex_rw_q;
        mem_dst_d = ex_dst_q;

        // EX takes the decode instruction. A bubble enters instead when the
        // ID/EX register is being flushed.
        ex_v_d    = validD & ~flushC;
        ex_rw_d   = RegWriteC;
        ex_ld_d   = MemToRegC;
        ex_dst_d  = destAddD;

        // The nearer producer (EX now, MEM next cycle) has priority. A match
        // against a load in EX never reaches here because that stalls and
        // sets flushC.
        fwd_sel1_d = FWD_RF;
        fwd_sel2_d = FWD_RF;
        if (!flushC) begin
            if (match_ex1) begin
                fwd_sel1_d = FWD_MEM;
            end else if (match_mem1) begin
                fwd_sel1_d = FWD_WB;
            end

            if (match_ex2) begin
                fwd_sel2_d = FWD_MEM;
            end else if (match_mem2) begin
                fwd_sel2_d = FWD_WB;
            end
        end

        stall_cnt_d = stall_cnt_q;
        if (load_use && !branchTakenE && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end

        flush_cnt_d = flush_cnt_q;
        if (branchTakenE && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_v_q      <= 1'b0;
            ex_rw_q     <= 1'b0;
            ex_ld_q     <= 1'b0;
            ex_dst_q    <= '0;
            mem_v_q     <= 1'b0;
            mem_rw_q    <= 1'b0;
            mem_dst_q   <= '0;
            fwd_sel1_q  <= FWD_RF;
            fwd_sel2_q  <= FWD_RF;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_v_q      <= ex_v_d;
            ex_rw_q     <= ex_rw_d;
            ex_ld_q     <= ex_ld_d;
            ex_dst_q    <= ex_dst_d;
            mem_v_q     <= mem_v_d;
            mem_rw_q    <= mem_rw_d;
            mem_dst_q   <= mem_dst_d;
            fwd_sel1_q  <= fwd_sel1_d;
            fwd_sel2_q  <= fwd_sel2_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign fwdSelE1   = fwd_sel1_q;
    assign fwdSelE2   = fwd_sel2_q;
    assign stallCount = stall_cnt_q;
    assign flushCount = flush_cnt_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit. Control outputs are checked in the cycle
// the decode inputs are driven. Expected forwarding selects are queued at
// drive time and compared after the next clock edge. A narrow counter
// instance keeps the saturation case short.
module tb_hazard_forward_unit;

    localparam int ADDR_W = 4;
    localparam int CNT_W  = 8;

    logic              clk;
    logic              reset;
    logic              validD;
    logic [ADDR_W-1:0] srcAddD1;
    logic [ADDR_W-1:0] srcAddD2;
    logic              useSrcD1;
    logic              useSrcD2;
    logic [ADDR_W-1:0] destAddD;
    logic              RegWriteC;
    logic              MemToRegC;
    logic              branchTakenE;
    logic              stallF;
    logic              stallD;
    logic              flushD;
    logic              flushC;
    logic [1:0]        fwdSelE1;
    logic [1:0]        fwdSelE2;
    logic [CNT_W-1:0]  stallCount;
    logic [CNT_W-1:0]  flushCount;

    int checks   = 0;
    int failures = 0;

    logic [3:0] exp_q[$];

    hazard_forward_unit #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .validD       (validD),
        .srcAddD1     (srcAddD1),
        .srcAddD2     (srcAddD2),
        .useSrcD1     (useSrcD1),
        .useSrcD2     (useSrcD2),
        .destAddD     (destAddD),
        .RegWriteC    (RegWriteC),
        .MemToRegC    (MemToRegC),
        .branchTakenE (branchTakenE),
        .stallF       (stallF),
        .stallD       (stallD),
        .flushD       (flushD),
        .flushC       (flushC),
        .fwdSelE1     (fwdSelE1),
        .fwdSelE2     (fwdSelE2),
        .stallCount   (stallCount),
        .flushCount   (flushCount)
    );

    // Clock / watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_cnt(input string tag, input logic [CNT_W-1:0] es, input logic [CNT_W-1:0] ef);
        chk({tag, " stallCount"}, 16'(stallCount), 16'(es));
        chk({tag, " flushCount"}, 16'(flushCount), 16'(ef));
    endtask

    // One decode cycle. exp_ctrl = {stallF, stallD, flushD, flushC} for
    // this cycle; e1/e2 = fwdSel expected in the following cycle.
    task automatic step(input logic rst, input logic v,
                        input logic [3:0] s1, input logic [3:0] s2,
                        input logic u1, input logic u2,
                        input logic [3:0] dst, input logic rw, input logic ld,
                        input logic br, input logic [3:0] exp_ctrl,
                        input logic [1:0] e1, input logic [1:0] e2,
                        input string tag);
        logic [3:0] exp_fwd;
        reset        = rst;
        validD       = v;
        srcAddD1     = s1;
        srcAddD2     = s2;
        useSrcD1     = u1;
        useSrcD2     = u2;
        destAddD     = dst;
        RegWriteC    = rw;
        MemToRegC    = ld;
        branchTakenE = br;
        #3;
        chk({tag, " ctrl"}, 16'({stallF, stallD, flushD, flushC}), 16'(exp_ctrl));
        exp_q.push_back({e1, e2});
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s fwd: expected queue empty", tag);
        end else begin
            exp_fwd = exp_q.pop_front();
            chk({tag, " fwd"}, 16'({fwdSelE1, fwdSelE2}), 16'(exp_fwd));
        end
    endtask

    task automatic nop(input string tag);
        step(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0,
             4'b0000, 2'b00, 2'b00, tag);
    endtask

    // Stimulus
    initial begin
        reset = 1'b1;
        validD = 1'b0; srcAddD1 = '0; srcAddD2 = '0; useSrcD1 = 1'b0; useSrcD2 = 1'b0;
        destAddD = '0; RegWriteC = 1'b0; MemToRegC = 1'b0; branchTakenE = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset ctrl", 16'({stallF, stallD, flushD, flushC}), 16'h0);
        chk("reset fwd", 16'({fwdSelE1, fwdSelE2}), 16'h0);
        chk_cnt("reset", 8'd0, 8'd0);

        // ALU R3 -> consumer src1 R3
        step(0, 1, 4'd0, 4'd0, 0, 0, 4'd3, 1, 0, 0, 4'b0000, 2'b00, 2'b00, "alu_w3");
        step(0, 1, 4'd3, 4'd4, 1, 1, 4'd8, 1, 0, 0, 4'b0000, 2'b01, 2'b00, "alu_r3");
        nop("nop1a"); nop("nop1b");

        // Load R5 -> consumer src2 R5: one stall cycle, then WB forward
        step(0, 1, 4'd0, 4'd0, 0, 0, 4'd5, 1, 1, 0, 4'b0000, 2'b00, 2'b00, "ld_w5");
        step(0, 1, 4'd1, 4'd5, 1, 1, 4'd9, 1, 0, 0, 4'b1101, 2'b00, 2'b00, "ld_use_stall");
        chk_cnt("after stall", 8'd1, 8'd0);
        step(0, 1, 4'd1, 4'd5, 1, 1, 4'd9, 1, 0, 0, 4'b0000, 2'b00, 2'b10, "ld_use_retry");
        chk_cnt("after retry", 8'd1, 8'd0);
        nop("nop2a"); nop("nop2b");

        // R7 writer, unrelated, reader -> WB forward on both operands
        step(0, 1, 4'd0, 4'd0, 0, 0, 4'd7, 1, 0, 0, 4'b0000, 2'b00, 2'b00, "w7");
        step(0, 1, 4'd0, 4'd1, 1, 1, 4'd2, 1, 0, 0, 4'b0000, 2'b00, 2'b00, "unrelated");
        step(0, 1, 4'd7, 4'd7, 1, 1, 4'd11, 0, 0, 0, 4'b0000, 2'b10, 2'b10, "r7_far");
        // Two R7 writers back to back -> nearer stage wins
        step(0, 1, 4'd0, 4'd0, 0, 0, 4'd7, 1, 0, 0, 4'b0000, 2'b00, 2'b00, "w7_a");
        step(0, 1, 4'd0, 4'd0, 0, 0, 4'd7, 1, 0, 0, 4'b0000, 2'b00, 2'b00, "w7_b");
        step(0, 1, 4'd7, 4'd6, 1, 1, 4'd12, 0, 0, 0, 4'b0000, 2'b01, 2'b00, "r7_near");
        nop("nop3a"); nop("nop3b");

        // Load-use coinciding with a taken branch: branch wins
        step(0, 1, 4'd0, 4'd0, 0, 0, 4'd5, 1, 1, 0, 4'b0000, 2'b00, 2'b00, "ld_w5_br");
        step(0, 1, 4'd5, 4'd0, 1, 0, 4'd9, 1, 0, 1, 4'b0011, 2'b00, 2'b00, "br_vs_ld");
        chk_cnt("after branch", 8'd1, 8'd1);
        nop("nop4a"); nop("nop4b");

        // useSrc=0 and validD=0 never stall or forward
        step(0, 1, 4'd0, 4'd0, 0, 0, 4'd5, 1, 1, 0, 4'b0000, 2'b00, 2'b00, "ld_w5_c");
        step(0, 1, 4'd5, 4'd0, 0, 1, 4'd10, 0, 0, 0, 4'b0000, 2'b00, 2'b00, "nouse_src1");
        step(0, 1, 4'd0, 4'd0, 0, 0, 4'd5, 1, 1, 0, 4'b0000, 2'b00, 2'b00, "ld_w5_d");
        step(0, 0, 4'd5, 4'd5, 1, 1, 4'd10, 0, 0, 0, 4'b0000, 2'b00, 2'b00, "invalid_d");
        nop("nop5a"); nop("nop5b");

        // Drive a self-dependent load repeatedly to saturate stallCount
        for (int i = 0; i < 600; i++) begin
            reset = 1'b0; validD = 1'b1; srcAddD1 = 4'd5; srcAddD2 = 4'd0;
            useSrcD1 = 1'b1; useSrcD2 = 1'b0; destAddD = 4'd5;
            RegWriteC = 1'b1; MemToRegC = 1'b1; branchTakenE = 1'b0;
            @(posedge clk);
            #1;
        end
        chk_cnt("saturated", 8'hFF, 8'd1);
        nop("nop6a"); nop("nop6b");
        step(0, 1, 4'd0, 4'd0, 0, 0, 4'd5, 1, 1, 0, 4'b0000, 2'b00, 2'b00, "ld_w5_e");
        step(0, 1, 4'd1, 4'd5, 1, 1, 4'd9, 1, 0, 0, 4'b1101, 2'b00, 2'b00, "sat_stall");
        chk_cnt("sat hold", 8'hFF, 8'd1);

        // Reset asserted during a load-use stall cycle
        step(0, 1, 4'd0, 4'd0, 0, 0, 4'd5, 1, 1, 0, 4'b0000, 2'b00, 2'b00, "ld_w5_f");
        step(1, 1, 4'd1, 4'd5, 1, 1, 4'd9, 1, 0, 0, 4'b0000, 2'b00, 2'b00, "reset_mid_stall");
        chk_cnt("after reset", 8'd0, 8'd0);
        step(0, 1, 4'd1, 4'd5, 1, 1, 4'd9, 1, 0, 0, 4'b0000, 2'b00, 2'b00, "post_reset");
        chk_cnt("post reset", 8'd0, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_forward_unit.md
Name: hazard_forward_unit

Overview:
Hazard detection and operand-forwarding control for the 4-stage (D, EX, MEM, WB) 16-bit core. Consumes the decode-side control and register addresses that feed the ID/EX pipeline register. Drives that register's flush, the fetch/decode stall lines, and registered forwarding selects aligned with the EX stage. Keeps a shadow copy of the EX and MEM stage write-back info and saturating performance counters for stalls and flushes.

Parameters:
ADDR_W, 4, register address width (16 architectural registers, none hardwired to zero)
CNT_W, 16, width of each performance counter

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-high reset
validD  in  1  decode stage holds a real instruction
srcAddD1  in  ADDR_W  source register 1 of the decode instruction
srcAddD2  in  ADDR_W  source register 2 of the decode instruction
useSrcD1  in  1  the decode instruction reads source 1
useSrcD2  in  1  the decode instruction reads source 2
destAddD  in  ADDR_W  destination register of the decode instruction
RegWriteC  in  1  the decode instruction writes a register
MemToRegC  in  1  the decode instruction is a load
branchTakenE  in  1  EX resolved a taken branch this cycle
stallF  out  1  hold the PC
stallD  out  1  hold the IF/ID register
flushD  out  1  clear the IF/ID register
flushC  out  1  insert a bubble into the ID/EX register
fwdSelE1  out  2  EX operand 1 source: 00 register file, 01 MEM-stage result, 10 WB-stage result
fwdSelE2  out  2  same for operand 2
stallCount  out  CNT_W  cycles with a load-use stall
flushCount  out  CNT_W  cycles with a branch flush

Behaviour:
- Shadow state: ex_{v,rw,ld,dst} and mem_{v,rw,dst}. Each edge does mem <= ex, then ex <= the decode info (validD, RegWriteC, MemToRegC, destAddD). When flushC=1, ex_v <= 0 instead.
- Match definitions:
  - matchEX(n) = validD & useSrcDn & ex_v & ex_rw & (ex_dst==srcAddDn).
  - matchMEM(n) uses the mem_* fields in the same way.
- Load-use stall: loadUse = ex_ld & (matchEX(1) | matchEX(2)).
- Branch: when branchTakenE=1, flushD=1 and flushC=1, with stallF=stallD=0. Branch has priority over loadUse.
- Otherwise when loadUse=1: stallF=stallD=1, flushC=1, flushD=0.
- Otherwise all four control outputs are 0.
- stallF, stallD, flushD and flushC are combinational from the current shadow state and inputs, and take effect in the same cycle.
- fwdSelEn is registered and becomes valid in the cycle the decode instruction occupies EX:
  - Next value is 00 if flushC=1.
  - Else 01 if matchEX(n) (and not a load, which is excluded by the stall).
  - Else 10 if matchMEM(n).
  - Else 00.
  - The nearer stage has priority.
- After a load-use stall, the load has moved to MEM while the dependent instruction is still in D, so the dependent instruction gets fwdSel=10.
- The register file provides same-cycle write-through, so an instruction three or more ahead needs no forwarding.
- Counters saturate at all-ones:
  - stallCount increments in every cycle where loadUse=1 and branchTakenE=0.
  - flushCount increments in every cycle where branchTakenE=1.
- Reset (sampled at the clock edge while high):
  - Clears all shadow valids, both fwdSels (to 00) and both counters.
  - While reset is high, stallF, stallD, flushD and flushC are forced to 0.
  - Reset mid-stall drops the stall at the next edge; there is no recovery state.
- validD=0 or useSrcDn=0 never produces a stall or forward for that operand.

Test Plan:
- ALU writes R3, next instruction reads R3 as src1 -> no stall; fwdSelE1=01 in the consumer's EX cycle; fwdSelE2=00.
- Load writes R5, next instruction reads R5 as src2 -> exactly one cycle with stallF=stallD=flushC=1 and stallCount 0->1; the following cycle has no stall and the consumer in EX sees fwdSelE2=10.
- Writer of R7, one unrelated instruction, then reader of R7 -> fwdSel=10. Two writers of R7 back-to-back, then reader -> fwdSel=01, the nearer stage wins.
- Load-use condition and branchTakenE in the same cycle -> flushD=flushC=1, stallF=stallD=0, flushCount increments and stallCount does not.
- Preload stallCount to all-ones by forcing repeated load-use -> it holds at 0xFFFF. Assert reset for one cycle mid-stall -> all outputs read 0 on the next cycle and the counters read 0.
- Reader with useSrcD1=0, or validD=0, matching an in-flight load -> no stall and fwdSel=00.
